// File: rtl/alu_sequencer_if.sv
// Command/response port of the ALU sequencer: one valid/ready command channel in,
// one valid/ready response channel out.
interface alu_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int AW     = 3
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic              cmd_cin;
  logic [AW-1:0]     cmd_rd;
  logic [AW-1:0]     cmd_ra;
  logic [AW-1:0]     cmd_rb;
  logic [DATA_W-1:0] cmd_imm;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_cin, cmd_rd, cmd_ra, cmd_rb, cmd_imm,
    input  cmd_ready,
    input  rsp_valid, rsp_data, rsp_err,
    output rsp_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_cin, cmd_rd, cmd_ra, cmd_rb, cmd_imm,
    output cmd_ready,
    output rsp_valid, rsp_data, rsp_err,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_sequencer.sv
// Command sequencer for an external 16-bit combinational ALU: register file, operand
// issue, settle-timed capture of acc, and a held valid/ready response.
module alu_sequencer #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int AW     = 3,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  alu_sequencer_if.slave    bus,
  output logic [DATA_W-1:0] alu_A,
  output logic [DATA_W-1:0] alu_B,
  output logic              alu_cin,
  output logic [2:0]        alu_s0,
  input  logic [DATA_W-1:0] alu_acc,
  output logic              busy,
  output logic [15:0]       ops_done
);

  localparam logic [2:0] OP_ALU_MAX = 3'b100;
  localparam logic [2:0] OP_LOADI   = 3'b101;
  localparam logic [2:0] OP_READ    = 3'b110;
  localparam logic [2:0] SETTLE_M1  = 3'(SETTLE - 1);

  // The capture step is the last ISSUE edge, so it has no state of its own.
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t                       state;
  logic [2:0]                   cnt;
  logic [AW-1:0]                rd_q;
  logic [NREG-1:0][DATA_W-1:0]  rf;
  logic                         rsp_valid;
  logic [DATA_W-1:0]            rsp_data;
  logic                         rsp_err;

  assign bus.cmd_ready = (state == IDLE);
  assign busy          = (state != IDLE);
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data;
  assign bus.rsp_err   = rsp_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rd_q      <= '0;
      rf        <= '0;
      alu_A     <= '0;
      alu_B     <= '0;
      alu_cin   <= 1'b0;
      alu_s0    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      ops_done  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            rd_q <= bus.cmd_rd;
            if (bus.cmd_op <= OP_ALU_MAX) begin
              alu_A   <= rf[bus.cmd_ra];
              alu_B   <= rf[bus.cmd_rb];
              alu_cin <= bus.cmd_cin;
              alu_s0  <= bus.cmd_op;
              cnt     <= SETTLE_M1;
              state   <= ISSUE;
            end else begin
              rsp_valid <= 1'b1;
              state     <= RESP;
              if (bus.cmd_op == OP_LOADI) begin
                rf[bus.cmd_rd] <= bus.cmd_imm;
                rsp_data       <= bus.cmd_imm;
                rsp_err        <= 1'b0;
              end else if (bus.cmd_op == OP_READ) begin
                rsp_data <= rf[bus.cmd_ra];
                rsp_err  <= 1'b0;
              end else begin
                rsp_data <= '0;
                rsp_err  <= 1'b1;
              end
            end
          end
        end
        ISSUE: begin
          // Operands have been stable for SETTLE cycles when cnt reaches zero.
          if (cnt == 3'd0) begin
            rf[rd_q]  <= alu_acc;
            rsp_data  <= alu_acc;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            ops_done  <= ops_done + 16'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized bench for alu_sequencer: an array-based register-file model predicts every
// response; a second SETTLE=3 instance checks capture timing against a changing acc.
module tb_alu_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_sequencer_if #(.DATA_W(16), .AW(3)) cif ();
  alu_sequencer_if #(.DATA_W(16), .AW(3)) cif3 ();

  logic [15:0] a_A, a_B, acc;
  logic        a_cin;
  logic [2:0]  a_s0;
  logic        busy;
  logic [15:0] ops_done;

  // ALU stub: add with carry regardless of s0.
  assign acc = a_A + a_B + {15'd0, a_cin};

  alu_sequencer #(.DATA_W(16), .NREG(8), .AW(3), .SETTLE(1)) u_dut (
    .clk(clk), .rst(rst), .bus(cif),
    .alu_A(a_A), .alu_B(a_B), .alu_cin(a_cin), .alu_s0(a_s0), .alu_acc(acc),
    .busy(busy), .ops_done(ops_done)
  );

  logic [15:0] b_A, b_B, acc3;
  logic        b_cin;
  logic [2:0]  b_s0;
  logic        busy3;
  logic [15:0] ops_done3;

  alu_sequencer #(.DATA_W(16), .NREG(8), .AW(3), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .bus(cif3),
    .alu_A(b_A), .alu_B(b_B), .alu_cin(b_cin), .alu_s0(b_s0), .alu_acc(acc3),
    .busy(busy3), .ops_done(ops_done3)
  );

  int checks   = 0;
  int failures = 0;

  logic [15:0] m_rf [8];
  logic [15:0] m_ops;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
    m_ops = 16'h0;
  endtask

  // Issue one command on the SETTLE=1 instance, hold the response for 'hold' cycles,
  // then accept it and update the model.
  task automatic run_cmd(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] ra,
                         input logic [2:0] rb, input logic [15:0] imm, input logic cin,
                         input int hold);
    logic [15:0] exp_d;
    logic        exp_e;
    logic [15:0] pA, pB;
    logic        pcin;
    logic [2:0]  ps0;
    int          lat;
    exp_e = 1'b0;
    if (op <= 3'd4)      exp_d = m_rf[ra] + m_rf[rb] + {15'd0, cin};
    else if (op == 3'd5) exp_d = imm;
    else if (op == 3'd6) exp_d = m_rf[ra];
    else begin exp_d = 16'h0; exp_e = 1'b1; end

    @(negedge clk);
    pA = a_A; pB = a_B; pcin = a_cin; ps0 = a_s0;
    chk("cmd_ready_idle", cif.cmd_ready, 1);
    chk("busy_idle", busy, 0);
    cif.cmd_op = op; cif.cmd_rd = rd; cif.cmd_ra = ra; cif.cmd_rb = rb;
    cif.cmd_imm = imm; cif.cmd_cin = cin; cif.cmd_valid = 1'b1;
    cif.rsp_ready = 1'b0;
    @(posedge clk); #1;
    cif.cmd_valid = 1'b0;
    lat = 0;
    while (!cif.rsp_valid && lat < 20) begin
      if (lat == 0) begin
        chk("issue_A", a_A, m_rf[ra]);
        chk("issue_B", a_B, m_rf[rb]);
        chk("issue_s0", a_s0, op);
        chk("issue_cin", a_cin, cin);
        chk("issue_busy", busy, 1);
      end
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, (op <= 3'd4) ? 1 : 0);
    chk("rsp_data", cif.rsp_data, exp_d);
    chk("rsp_err", cif.rsp_err, exp_e);
    if (op > 3'd4) begin
      chk("alu_hold", {a_A, a_B}, {pA, pB});
      chk("alu_hold_ctl", {a_cin, a_s0}, {pcin, ps0});
    end
    for (int i = 0; i < hold; i++) begin
      if (i == 1) begin
        // Stray command while busy must be ignored.
        cif.cmd_op = 3'd5; cif.cmd_rd = 3'd7; cif.cmd_imm = 16'hDEAD; cif.cmd_valid = 1'b1;
      end
      @(posedge clk); #1;
      cif.cmd_valid = 1'b0;
      chk("hold_valid", cif.rsp_valid, 1);
      chk("hold_data", cif.rsp_data, exp_d);
      chk("hold_ready", cif.cmd_ready, 0);
    end
    cif.rsp_ready = 1'b1;
    @(posedge clk); #1;
    cif.rsp_ready = 1'b0;
    if (op <= 3'd5) m_rf[rd] = exp_d;
    m_ops = m_ops + 16'd1;
    chk("rsp_clear", cif.rsp_valid, 0);
    chk("err_clear", cif.rsp_err, 0);
    chk("ops_done", ops_done, m_ops);
  endtask

  // SETTLE=3 instance: acc changes every cycle; the value present at the third edge
  // after accept must be captured, written back and readable.
  task automatic run_settle3(input logic [2:0] rd);
    logic [15:0] exp_d;
    int          lat;
    @(negedge clk);
    acc3 = 16'($urandom);
    exp_d = acc3;
    cif3.cmd_op = 3'd0; cif3.cmd_rd = rd; cif3.cmd_ra = 3'd0; cif3.cmd_rb = 3'd0;
    cif3.cmd_cin = 1'b0; cif3.cmd_imm = 16'h0; cif3.cmd_valid = 1'b1;
    @(posedge clk); #1;
    cif3.cmd_valid = 1'b0;
    lat = 0;
    while (!cif3.rsp_valid && lat < 20) begin
      @(negedge clk);
      acc3 = 16'($urandom);
      exp_d = acc3;
      @(posedge clk); #1;
      lat++;
    end
    chk("s3_latency", lat, 3);
    chk("s3_data", cif3.rsp_data, exp_d);
    @(negedge clk);
    acc3 = ~exp_d;
    cif3.rsp_ready = 1'b1;
    @(posedge clk); #1;
    cif3.rsp_ready = 1'b0;
    @(negedge clk);
    cif3.cmd_op = 3'd6; cif3.cmd_ra = rd; cif3.cmd_valid = 1'b1;
    @(posedge clk); #1;
    cif3.cmd_valid = 1'b0;
    chk("s3_read_valid", cif3.rsp_valid, 1);
    chk("s3_read_data", cif3.rsp_data, exp_d);
    cif3.rsp_ready = 1'b1;
    @(posedge clk); #1;
    cif3.rsp_ready = 1'b0;
  endtask

  initial begin
    cif.cmd_valid = 0; cif.cmd_op = 0; cif.cmd_cin = 0; cif.cmd_rd = 0; cif.cmd_ra = 0;
    cif.cmd_rb = 0; cif.cmd_imm = 0; cif.rsp_ready = 0;
    cif3.cmd_valid = 0; cif3.cmd_op = 0; cif3.cmd_cin = 0; cif3.cmd_rd = 0; cif3.cmd_ra = 0;
    cif3.cmd_rb = 0; cif3.cmd_imm = 0; cif3.rsp_ready = 0;
    acc3 = 16'h0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", cif.cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_valid", cif.rsp_valid, 0);
    chk("rst_data", cif.rsp_data, 0);
    chk("rst_err", cif.rsp_err, 0);
    chk("rst_ops", ops_done, 0);
    chk("rst_alu", {a_A, a_B}, 0);
    chk("rst_alu_ctl", {a_cin, a_s0}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed sequence
    run_cmd(3'd6, 3'd0, 3'd3, 3'd0, 16'h0, 1'b0, 0);
    run_cmd(3'd5, 3'd1, 3'd0, 3'd0, 16'hC972, 1'b0, 0);
    run_cmd(3'd5, 3'd2, 3'd0, 3'd0, 16'hED0C, 1'b0, 0);
    run_cmd(3'd0, 3'd3, 3'd1, 3'd2, 16'h0, 1'b0, 0);
    chk("m_r3", m_rf[3], 16'hB67E);
    run_cmd(3'd6, 3'd0, 3'd3, 3'd0, 16'h0, 1'b0, 0);
    run_cmd(3'd4, 3'd4, 3'd1, 3'd2, 16'h0, 1'b1, 5);
    run_cmd(3'd6, 3'd0, 3'd7, 3'd0, 16'h0, 1'b0, 0);
    run_cmd(3'd7, 3'd1, 3'd0, 3'd0, 16'h0, 1'b0, 0);
    run_cmd(3'd6, 3'd0, 3'd1, 3'd0, 16'h0, 1'b0, 0);
    run_cmd(3'd0, 3'd1, 3'd1, 3'd1, 16'h0, 1'b1, 0);
    run_cmd(3'd6, 3'd0, 3'd1, 3'd0, 16'h0, 1'b0, 0);

    // Reset during ISSUE aborts the command
    @(negedge clk);
    cif.cmd_op = 3'd0; cif.cmd_rd = 3'd5; cif.cmd_ra = 3'd1; cif.cmd_rb = 3'd2;
    cif.cmd_cin = 1'b0; cif.cmd_valid = 1'b1;
    @(posedge clk); #1;
    cif.cmd_valid = 1'b0;
    chk("abort_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("abort_valid", cif.rsp_valid, 0);
    chk("abort_ops", ops_done, 0);
    chk("abort_ready", cif.cmd_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (2) begin
      @(posedge clk); #1;
      chk("abort_no_rsp", cif.rsp_valid, 0);
    end
    run_cmd(3'd6, 3'd0, 3'd5, 3'd0, 16'h0, 1'b0, 0);

    // Random traffic against the model
    for (int n = 0; n < 60; n++) begin
      run_cmd(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom), 3'($urandom),
              16'($urandom), 1'($urandom), $urandom_range(0, 3));
    end
    for (int r = 0; r < 8; r++) run_cmd(3'd6, 3'd0, 3'(r), 3'd0, 16'h0, 1'b0, 0);

    for (int k = 0; k < 4; k++) run_settle3(3'(k + 2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
